// File: rtl/spsram_rr_arb.sv
// Two-port round-robin arbiter/sequencer for a single-port 16384x128 SRAM with burst locking.
// Optional performance counters are built in when SPSRAM_ARB_PERF_CNT_EN is defined.
module spsram_rr_arb #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned DATA_W    = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_req,
   input  logic                  p0_last,
   input  logic                  p0_we,
   input  logic [ADDR_W-1:0]     p0_addr,
   input  logic [DATA_W/8-1:0]   p0_wstrb,
   input  logic [DATA_W-1:0]     p0_wdata,
   input  logic                  p1_req,
   input  logic                  p1_last,
   input  logic                  p1_we,
   input  logic [ADDR_W-1:0]     p1_addr,
   input  logic [DATA_W/8-1:0]   p1_wstrb,
   input  logic [DATA_W-1:0]     p1_wdata,
   output logic                  p0_gnt,
   output logic                  p1_gnt,
   output logic                  p0_rvalid,
   output logic                  p1_rvalid,
   output logic [DATA_W-1:0]     p0_rdata,
   output logic [DATA_W-1:0]     p1_rdata,
   output logic                  mem_cen,
   output logic                  mem_gwen,
   output logic [DATA_W-1:0]     mem_wen,
   output logic [ADDR_W-1:0]     mem_a,
   output logic [DATA_W-1:0]     mem_d,
   input  logic [DATA_W-1:0]     mem_q,
   output logic [31:0]           perf_gnt0,
   output logic [31:0]           perf_gnt1,
   output logic [31:0]           perf_stall0,
   output logic [31:0]           perf_stall1
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = 5;

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t              r_state;
   logic                r_prio;
   logic                r_owner;
   logic [CNT_W-1:0]    r_beat_cnt;
   logic                r_rvalid0;
   logic                r_rvalid1;
   logic [ADDR_W-1:0]   r_mem_a;
   logic [DATA_W-1:0]   r_mem_d;

   logic                w_winner;
   logic                w_any;
   logic                w_last;
   logic                w_we;
   logic                w_done;
   logic [ADDR_W-1:0]   w_addr;
   logic [STRB_W-1:0]   w_strb;
   logic [DATA_W-1:0]   w_wdata;
   logic [CNT_W-1:0]    w_cnt_next;

   // Winner selection: owner while locked, otherwise the lone requester or prio on contention.
   always_comb begin
      w_winner = 1'b0;
      w_any    = 1'b0;
      if (r_state == ST_LOCKED) begin
         w_winner = r_owner;
         w_any    = r_owner ? p1_req : p0_req;
      end else begin
         w_any    = p0_req | p1_req;
         w_winner = (p0_req & p1_req) ? r_prio : p1_req;
      end
      if (rst) w_any = 1'b0;
   end

   assign p0_gnt  = w_any & ~w_winner;
   assign p1_gnt  = w_any &  w_winner;
   assign w_last  = w_winner ? p1_last  : p0_last;
   assign w_we    = w_winner ? p1_we    : p0_we;
   assign w_addr  = w_winner ? p1_addr  : p0_addr;
   assign w_strb  = w_winner ? p1_wstrb : p0_wstrb;
   assign w_wdata = w_winner ? p1_wdata : p0_wdata;

   assign w_cnt_next = (r_state == ST_LOCKED) ? (r_beat_cnt + CNT_W'(1)) : CNT_W'(1);
   assign w_done     = w_last | (w_cnt_next == CNT_W'(MAX_BURST));

   // Burst lock FSM, round-robin priority and read-valid pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_prio     <= 1'b0;
         r_owner    <= 1'b0;
         r_beat_cnt <= '0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
      end else begin
         r_rvalid0 <= p0_gnt & ~p0_we;
         r_rvalid1 <= p1_gnt & ~p1_we;
         if (w_any) begin
            if (w_done) begin
               r_state    <= ST_IDLE;
               r_prio     <= ~w_winner;
               r_beat_cnt <= '0;
            end else begin
               r_state    <= ST_LOCKED;
               r_owner    <= w_winner;
               r_beat_cnt <= w_cnt_next;
            end
         end
      end
   end

   // Address/data hold their last granted value while the SRAM is idle.
   always_ff @(posedge clk) begin
      if (w_any) begin
         r_mem_a <= w_addr;
         r_mem_d <= w_wdata;
      end
   end

   always_comb begin
      mem_cen  = 1'b1;
      mem_gwen = 1'b1;
      mem_wen  = '1;
      mem_a    = r_mem_a;
      mem_d    = r_mem_d;
      if (w_any) begin
         mem_cen = 1'b0;
         mem_a   = w_addr;
         mem_d   = w_wdata;
         // An all-zero strobe write is granted but leaves the array untouched.
         if (w_we && (|w_strb)) begin
            mem_gwen = 1'b0;
            for (int unsigned j = 0; j < STRB_W; j++) begin
               mem_wen[8*j +: 8] = {8{~w_strb[j]}};
            end
         end
      end
   end

   assign p0_rvalid = r_rvalid0;
   assign p1_rvalid = r_rvalid1;
   assign p0_rdata  = mem_q;
   assign p1_rdata  = mem_q;

`ifdef SPSRAM_ARB_PERF_CNT_EN
   logic [31:0] r_perf_gnt0;
   logic [31:0] r_perf_gnt1;
   logic [31:0] r_perf_stall0;
   logic [31:0] r_perf_stall1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_gnt0   <= '0;
         r_perf_gnt1   <= '0;
         r_perf_stall0 <= '0;
         r_perf_stall1 <= '0;
      end else begin
         if (p0_gnt)            r_perf_gnt0   <= r_perf_gnt0   + 32'd1;
         if (p1_gnt)            r_perf_gnt1   <= r_perf_gnt1   + 32'd1;
         if (p0_req && !p0_gnt) r_perf_stall0 <= r_perf_stall0 + 32'd1;
         if (p1_req && !p1_gnt) r_perf_stall1 <= r_perf_stall1 + 32'd1;
      end
   end

   assign perf_gnt0   = r_perf_gnt0;
   assign perf_gnt1   = r_perf_gnt1;
   assign perf_stall0 = r_perf_stall0;
   assign perf_stall1 = r_perf_stall1;
`else
   assign perf_gnt0   = '0;
   assign perf_gnt1   = '0;
   assign perf_stall0 = '0;
   assign perf_stall1 = '0;
`endif

endmodule
